rasterizer_cmd_queue: RTL and testbench

- Parametrised CPU-to-rasterizer command path. Buffers up to DEPTH raster commands (command, two coordinate pairs, colour) in a FIFO, so the CPU no longer stalls on every submit while the rasterizer is busy.
- Issues queued commands to the rasterizer in order, as registered one-cycle execute pulses.
- Sits between the CPU execute stage and the rasterizer. Adds queue status, flush and sticky overflow reporting.

---
 rtl/common_pkg.sv | 15 +
 rtl/fifo_sync.sv | 58 +++++
 rtl/rasterizer_cmd_queue.sv | 119 +++++++++++
 tb/tb_rasterizer_cmd_queue.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/common_pkg.sv
// Shared raster command encoding and default payload widths.
package common;

    localparam int COORD_W_DEFAULT  = 8;
    localparam int COLOUR_W_DEFAULT = 3;

    // Encoding 0 is the idle/no-op command, so reset payloads read as NOP.
    typedef enum logic [1:0] {
        RC_NOP  = 2'd0,
        RC_LINE = 2'd1,
        RC_RECT = 2'd2,
        RC_FILL = 2'd3
    } raster_command_t;

endpackage

// File: rtl/fifo_sync.sv
// Generic single-clock FIFO with flush. Read data is the tail entry, always
// visible. Pushes into a full FIFO and pops from an empty one are ignored.
// A flush wins over a same-cycle push or pop.
module fifo_sync #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           i_push,
    input  logic                           i_pop,
    input  logic                           i_flush,
    input  logic [WIDTH-1:0]               i_data,
    output logic [WIDTH-1:0]               o_data,
    output logic [$clog2(DEPTH+1)-1:0]     o_count,
    output logic                           o_full,
    output logic                           o_empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_head;
    logic [AW-1:0]    r_tail;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign w_push  = i_push && !o_full  && !i_flush;
    assign w_pop   = i_pop  && !o_empty && !i_flush;
    assign o_data  = r_mem[r_tail];
    assign o_count = r_count;

    // Storage write at the head; contents need no reset since count gates reads.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_head] <= i_data;
    end

    // Pointer and occupancy tracking; DEPTH is a power of two so pointers wrap naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_tail  <= r_head;
            r_count <= '0;
        end else begin
            if (w_push) r_head <= r_head + 1'b1;
            if (w_pop)  r_tail <= r_tail + 1'b1;
            if (w_push && !w_pop)      r_count <= r_count + 1'b1;
            else if (w_pop && !w_push) r_count <= r_count - 1'b1;
        end
    end

endmodule

// File: rtl/rasterizer_cmd_queue.sv
// CPU-to-rasterizer command queue: buffers raster commands and issues them
// in order as registered one-cycle execute pulses, with flush and a sticky
// overflow flag for submits that arrive while the queue is full.
module rasterizer_cmd_queue
    import common::*;
#(
    parameter int DEPTH    = 4,
    parameter int COORD_W  = COORD_W_DEFAULT,
    parameter int COLOUR_W = COLOUR_W_DEFAULT
) (
    input  logic                         clk,
    input  logic                         rst_async,
    input  raster_command_t              cpu_command,
    input  logic [COORD_W-1:0]           cpu_x0,
    input  logic [COORD_W-1:0]           cpu_y0,
    input  logic [COORD_W-1:0]           cpu_x1,
    input  logic [COORD_W-1:0]           cpu_y1,
    input  logic [COLOUR_W-1:0]          cpu_colour,
    input  logic                         cpu_submit,
    input  logic                         cpu_flush,
    input  logic                         cpu_clear_overflow,
    output logic                         queue_full,
    output logic [$clog2(DEPTH+1)-1:0]   queue_count,
    output logic                         gpu_idle,
    output logic                         overflow,
    output raster_command_t              rast_command,
    output logic [COORD_W-1:0]           rast_x0,
    output logic [COORD_W-1:0]           rast_y0,
    output logic [COORD_W-1:0]           rast_x1,
    output logic [COORD_W-1:0]           rast_y1,
    output logic [COLOUR_W-1:0]          rast_colour,
    output logic                         rast_execute_request,
    input  logic                         rast_busy
);
    localparam int CMD_W   = $bits(raster_command_t);
    localparam int ENTRY_W = CMD_W + 4*COORD_W + COLOUR_W;

    logic [ENTRY_W-1:0]  w_entry_in;
    logic [ENTRY_W-1:0]  w_entry_out;
    logic [CMD_W-1:0]    w_cmd_bits;
    logic [COORD_W-1:0]  w_x0, w_y0, w_x1, w_y1;
    logic [COLOUR_W-1:0] w_colour;
    logic                w_full;
    logic                w_empty;
    logic                w_push;
    logic                w_pop;

    raster_command_t     r_command;
    logic [COORD_W-1:0]  r_x0, r_y0, r_x1, r_y1;
    logic [COLOUR_W-1:0] r_colour;
    logic                r_req;
    logic                r_overflow;

    assign w_entry_in = {cpu_command, cpu_x0, cpu_y0, cpu_x1, cpu_y1, cpu_colour};
    assign {w_cmd_bits, w_x0, w_y0, w_x1, w_y1, w_colour} = w_entry_out;

    // Full is judged on the current count, so a same-cycle pop never makes room.
    assign w_push = cpu_submit && !w_full && !cpu_flush;
    // Issue holdoff: never pop while a pulse is out, so pulses are >= 2 cycles apart.
    assign w_pop  = !w_empty && !rast_busy && !r_req && !cpu_flush;

    fifo_sync #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst_async),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (cpu_flush),
        .i_data  (w_entry_in),
        .o_data  (w_entry_out),
        .o_count (queue_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Issue stage: latch the tail entry and raise a single-cycle execute pulse.
    always_ff @(posedge clk or posedge rst_async) begin
        if (rst_async) begin
            r_req     <= 1'b0;
            r_command <= RC_NOP;
            r_x0      <= '0;
            r_y0      <= '0;
            r_x1      <= '0;
            r_y1      <= '0;
            r_colour  <= '0;
        end else begin
            r_req <= w_pop;
            if (w_pop) begin
                r_command <= raster_command_t'(w_cmd_bits);
                r_x0      <= w_x0;
                r_y0      <= w_y0;
                r_x1      <= w_x1;
                r_y1      <= w_y1;
                r_colour  <= w_colour;
            end
        end
    end

    // Sticky overflow: set beats clear; a submit dropped by flush is not an overflow.
    always_ff @(posedge clk or posedge rst_async) begin
        if (rst_async)                                 r_overflow <= 1'b0;
        else if (cpu_submit && w_full && !cpu_flush)   r_overflow <= 1'b1;
        else if (cpu_clear_overflow)                   r_overflow <= 1'b0;
    end

    assign queue_full           = w_full;
    assign overflow             = r_overflow;
    assign gpu_idle             = w_empty && !rast_busy && !r_req;
    assign rast_execute_request = r_req;
    assign rast_command         = r_command;
    assign rast_x0              = r_x0;
    assign rast_y0              = r_y0;
    assign rast_x1              = r_x1;
    assign rast_y1              = r_y1;
    assign rast_colour          = r_colour;

endmodule

// File: tb/tb_rasterizer_cmd_queue.sv
// Scoreboard bench for rasterizer_cmd_queue: a queue-level reference model
// predicts issues and status; a negedge monitor compares the DUT against it.
module tb_rasterizer_cmd_queue;
    import common::*;

    localparam int DEPTH = 4;
    localparam int CW    = 8;
    localparam int LW    = 3;
    localparam int NW    = $clog2(DEPTH+1);
    localparam int BD    = 8;
    localparam int BCW   = 10;
    localparam int BLW   = 6;
    localparam int BNW   = $clog2(BD+1);

    typedef struct packed {
        raster_command_t c;
        logic [CW-1:0]   x0, y0, x1, y1;
        logic [LW-1:0]   col;
    } ent_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // instance A (default widths)
    raster_command_t cmd = RC_NOP;
    logic [CW-1:0]   x0 = '0, y0 = '0, x1 = '0, y1 = '0;
    logic [LW-1:0]   col = '0;
    logic            sub = 0, flush = 0, clr = 0, busy = 0;
    logic            full, idle, ovf, req;
    logic [NW-1:0]   cnt;
    raster_command_t r_cmd;
    logic [CW-1:0]   r_x0, r_y0, r_x1, r_y1;
    logic [LW-1:0]   r_col;

    rasterizer_cmd_queue #(.DEPTH(DEPTH), .COORD_W(CW), .COLOUR_W(LW)) dut (
        .clk(clk), .rst_async(rst),
        .cpu_command(cmd), .cpu_x0(x0), .cpu_y0(y0), .cpu_x1(x1), .cpu_y1(y1),
        .cpu_colour(col), .cpu_submit(sub), .cpu_flush(flush),
        .cpu_clear_overflow(clr),
        .queue_full(full), .queue_count(cnt), .gpu_idle(idle), .overflow(ovf),
        .rast_command(r_cmd), .rast_x0(r_x0), .rast_y0(r_y0), .rast_x1(r_x1),
        .rast_y1(r_y1), .rast_colour(r_col), .rast_execute_request(req),
        .rast_busy(busy)
    );

    // instance B (wide payload, deeper queue)
    raster_command_t b_cmd = RC_NOP;
    logic [BCW-1:0]  b_x0 = '0, b_y0 = '0, b_x1 = '0, b_y1 = '0;
    logic [BLW-1:0]  b_col = '0;
    logic            b_sub = 0;
    logic            b_full, b_idle, b_ovf, b_req;
    logic [BNW-1:0]  b_cnt;
    raster_command_t b_rcmd;
    logic [BCW-1:0]  b_rx0, b_ry0, b_rx1, b_ry1;
    logic [BLW-1:0]  b_rcol;

    rasterizer_cmd_queue #(.DEPTH(BD), .COORD_W(BCW), .COLOUR_W(BLW)) dut_b (
        .clk(clk), .rst_async(rst),
        .cpu_command(b_cmd), .cpu_x0(b_x0), .cpu_y0(b_y0), .cpu_x1(b_x1), .cpu_y1(b_y1),
        .cpu_colour(b_col), .cpu_submit(b_sub), .cpu_flush(1'b0),
        .cpu_clear_overflow(1'b0),
        .queue_full(b_full), .queue_count(b_cnt), .gpu_idle(b_idle), .overflow(b_ovf),
        .rast_command(b_rcmd), .rast_x0(b_rx0), .rast_y0(b_ry0), .rast_x1(b_rx1),
        .rast_y1(b_ry1), .rast_colour(b_rcol), .rast_execute_request(b_req),
        .rast_busy(1'b0)
    );

    int   total = 0;
    int   bad   = 0;
    ent_t mq[$];       // model: entries queued, not yet issued
    ent_t exq[$];      // scoreboard: issued entries awaiting the DUT pulse
    bit   m_req = 0;   // model: pulse expected in the current cycle
    bit   m_ovf = 0;
    ent_t m_last = '0; // last payload seen issued

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: applies the queue rules to sampled inputs at each edge.
    initial begin
        bit   mfull, mpop;
        ent_t e;
        forever begin
            @(posedge clk);
            if (rst) begin
                mq.delete(); exq.delete(); m_req = 0; m_ovf = 0;
            end else if (flush) begin
                mq.delete();
                m_req = 0;
                if (clr) m_ovf = 0;
            end else begin
                mfull = (mq.size() == DEPTH);
                mpop  = (mq.size() != 0) && !busy && !m_req;
                if (sub && mfull) m_ovf = 1;
                else if (clr)     m_ovf = 0;
                if (mpop) begin
                    e = mq.pop_front();
                    exq.push_back(e);
                end
                if (sub && !mfull) mq.push_back(ent_t'({cmd, x0, y0, x1, y1, col}));
                m_req = mpop;
            end
        end
    end

    // Monitor: status every cycle, payload popped from the scoreboard on each pulse.
    initial begin
        ent_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                m_last = '0;
            end else begin
                chk("req",   req,  m_req);
                chk("count", cnt,  mq.size());
                chk("full",  full, mq.size() == DEPTH);
                chk("ovf",   ovf,  m_ovf);
                chk("idle",  idle, mq.size() == 0 && !busy && !m_req);
                if (req) begin
                    if (exq.size() == 0) begin
                        total++; bad++;
                        $display("FAIL pulse actual=1 expected=no-issue at %0t", $time);
                    end else begin
                        e = exq.pop_front();
                        m_last = e;
                    end
                end
                chk("payload", {r_cmd, r_x0, r_y0, r_x1, r_y1, r_col}, m_last);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic submit(input raster_command_t c, input int ax0, input int ay0,
                          input int ax1, input int ay1, input int acol);
        cmd = c; x0 = CW'(ax0); y0 = CW'(ay0); x1 = CW'(ax1); y1 = CW'(ay1);
        col = LW'(acol); sub = 1;
        cyc();
        sub = 0;
    endtask

    task automatic submit_rnd();
        submit(raster_command_t'($urandom_range(0, 3)), $urandom_range(0, 255),
               $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255),
               $urandom_range(0, 7));
    endtask

    task automatic wait_cyc(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic do_reset();
        rst = 1;
        wait_cyc(2);
        @(negedge clk);
        rst = 0;
        cyc();
    endtask

    initial begin
        // reset state
        #1;
        chk("rst_req",   req,  0);
        chk("rst_count", cnt,  0);
        chk("rst_full",  full, 0);
        chk("rst_ovf",   ovf,  0);
        chk("rst_payload", {r_cmd, r_x0, r_y0, r_x1, r_y1, r_col}, 0);
        do_reset();

        // single command, idle rasterizer; rasterizer busy for a while after
        submit(RC_LINE, 0, 0, 10, 20, 5);
        wait_cyc(1);
        busy = 1;
        wait_cyc(3);
        busy = 0;
        wait_cyc(3);

        // burst into busy rasterizer, then overflow handling
        busy = 1;
        for (int i = 0; i < 4; i++) submit_rnd();
        submit_rnd();                       // dropped, sets overflow
        clr = 1; submit_rnd(); clr = 0;     // set beats clear
        clr = 1; cyc(); clr = 0;            // clear alone
        busy = 0;
        wait_cyc(12);

        // steady push/pop around count 2 across pointer wrap, both phases
        busy = 1;
        submit_rnd(); submit_rnd();
        busy = 0;
        for (int i = 0; i < 3*DEPTH; i++) begin submit_rnd(); cyc(); end
        cyc();
        for (int i = 0; i < 3*DEPTH; i++) begin submit_rnd(); cyc(); end
        wait_cyc(10);

        // flush with 3 entries, a pulse in flight and a same-cycle submit
        busy = 1;
        submit_rnd(); submit_rnd(); submit_rnd(); submit_rnd();
        submit_rnd();                       // overflow set, must survive flush
        busy = 0;
        cyc();                              // pop edge: pulse visible this cycle
        flush = 1; sub = 1; cyc(); flush = 0; sub = 0;
        wait_cyc(6);

        // randomized traffic
        for (int i = 0; i < 500; i++) begin
            cmd   = raster_command_t'($urandom_range(0, 3));
            x0    = CW'($urandom); y0 = CW'($urandom);
            x1    = CW'($urandom); y1 = CW'($urandom);
            col   = LW'($urandom);
            sub   = ($urandom_range(0, 99) < 60);
            busy  = ($urandom_range(0, 99) < 40);
            flush = ($urandom_range(0, 99) < 3);
            clr   = ($urandom_range(0, 99) < 5);
            cyc();
        end
        sub = 0; flush = 0; clr = 0; busy = 0;
        wait_cyc(12);
        chk("drained", exq.size(), 0);

        // async reset between edges while a pulse is out
        busy = 1;
        for (int i = 0; i < 5; i++) submit_rnd();
        busy = 0;
        cyc();
        #2 rst = 1;
        #1;
        chk("arst_req",   req,  0);
        chk("arst_count", cnt,  0);
        chk("arst_full",  full, 0);
        chk("arst_ovf",   ovf,  0);
        chk("arst_idle",  idle, 1);
        chk("arst_payload", {r_cmd, r_x0, r_y0, r_x1, r_y1, r_col}, 0);
        cyc();
        @(negedge clk);
        rst = 0;
        cyc();

        // wide instance: coordinates above 255, 6-bit colour
        b_cmd = RC_RECT; b_x0 = 10'd300; b_y0 = 10'd511; b_x1 = 10'd1000; b_y1 = 10'd700;
        b_col = 6'd45; b_sub = 1;
        cyc();
        b_sub = 0;
        chk("b_req_n1", b_req, 0);
        chk("b_cnt_n1", b_cnt, 1);
        cyc();
        chk("b_req_n2", b_req, 1);
        chk("b_payload", {b_rcmd, b_rx0, b_ry0, b_rx1, b_ry1, b_rcol},
            {RC_RECT, 10'd300, 10'd511, 10'd1000, 10'd700, 6'd45});
        chk("b_cnt_n2", b_cnt, 0);
        cyc();
        chk("b_req_n3", b_req, 0);
        chk("b_idle",   b_idle, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
